// File: rtl/anubis_pkg.sv
// Shared definitions for the Anubis-128 datapath.
//  - ROUNDS / DATA_W: round count and block width.
//  - state_e: decrypt FSM state encoding.
//  - byte_msb(): byte k of a block sits at [byte_msb(k) -: 8], byte 0 = MSB,
//    row-major 4x4 matrix (byte 4*row + col).
//  - xtime(): multiply by x in GF(2^8) mod x^8+x^4+x^3+x^2+1.
//  - sbox(): the involutional S-box, built from the P and Q mini-boxes.
package anubis_pkg;

    localparam int ROUNDS = 12;
    localparam int DATA_W = 128;
    localparam int BYTE_W = 8;
    localparam int NBYTES = DATA_W / BYTE_W;

    typedef enum logic [2:0] {
        ST_IDLE, ST_KEY0, ST_FETCH, ST_GAMMA, ST_TAU, ST_THETA, ST_SIGMA, ST_DONE
    } state_e;

    // Mini-boxes, entry 0 in the top nibble. Both are involutions.
    localparam logic [63:0] P_BOX = 64'h3FE0_54BC_DA96_7821;
    localparam logic [63:0] Q_BOX = 64'h9E56_A23C_F04D_7B18;

    function automatic int byte_msb(input int k);
        return DATA_W - 1 - BYTE_W * k;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1D : 8'h00);
    endfunction

    function automatic logic [3:0] mini_p(input logic [3:0] x);
        return P_BOX[63 - 4 * int'(x) -: 4];
    endfunction

    function automatic logic [3:0] mini_q(input logic [3:0] x);
        return Q_BOX[63 - 4 * int'(x) -: 4];
    endfunction

    // Three mini-box layers (P|Q, Q|P, P|Q) with a bit exchange between
    // layers: hi <- {hi[3:2], lo[3:2]}, lo <- {hi[1:0], lo[1:0]}.
    // The palindromic arrangement keeps the whole S-box an involution.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [3:0] hi, lo;
        logic [7:0] t;
        hi = mini_p(x[7:4]);
        lo = mini_q(x[3:0]);
        t  = {hi[3:2], lo[3:2], hi[1:0], lo[1:0]};
        hi = mini_q(t[7:4]);
        lo = mini_p(t[3:0]);
        t  = {hi[3:2], lo[3:2], hi[1:0], lo[1:0]};
        return {mini_p(t[7:4]), mini_q(t[3:0])};
    endfunction

endpackage

// File: rtl/anubis_gamma.sv
// gamma step: S-box applied to every byte of the block (combinational).
//  a_i  in  128  input block
//  b_o  out 128  substituted block
module anubis_gamma
    import anubis_pkg::*;
(
    input  logic [DATA_W-1:0] a_i,
    output logic [DATA_W-1:0] b_o
);
    for (genvar k = 0; k < NBYTES; k++) begin : g_byte
        assign b_o[byte_msb(k) -: 8] = sbox(a_i[byte_msb(k) -: 8]);
    end
endmodule

// File: rtl/anubis_tau.sv
// tau step: transpose of the 4x4 byte matrix (combinational).
//  a_i  in  128  input block
//  b_o  out 128  transposed block
module anubis_tau
    import anubis_pkg::*;
(
    input  logic [DATA_W-1:0] a_i,
    output logic [DATA_W-1:0] b_o
);
    for (genvar i = 0; i < 4; i++) begin : g_row
        for (genvar j = 0; j < 4; j++) begin : g_col
            assign b_o[byte_msb(4*i + j) -: 8] = a_i[byte_msb(4*j + i) -: 8];
        end
    end
endmodule

// File: rtl/anubis_theta.sv
// theta step: each row multiplied by H = had(01,02,04,06) over GF(2^8)
// (combinational). H*H = I, so theta is its own inverse.
//  a_i  in  128  input block
//  b_o  out 128  mixed block
module anubis_theta
    import anubis_pkg::*;
(
    input  logic [DATA_W-1:0] a_i,
    output logic [DATA_W-1:0] b_o
);
    for (genvar i = 0; i < 4; i++) begin : g_row
        for (genvar j = 0; j < 4; j++) begin : g_col
            logic [7:0] a0, a1, a2, a3;
            // H[k][j] = h[k^j]: column j picks coefficient h[m] for a[i][j^m]
            assign a0 = a_i[byte_msb(4*i + j) -: 8];
            assign a1 = a_i[byte_msb(4*i + (j ^ 1)) -: 8];
            assign a2 = a_i[byte_msb(4*i + (j ^ 2)) -: 8];
            assign a3 = a_i[byte_msb(4*i + (j ^ 3)) -: 8];
            assign b_o[byte_msb(4*i + j) -: 8] =
                a0 ^ xtime(a1) ^ xtime(xtime(a2)) ^ xtime(xtime(a3)) ^ xtime(a3);
        end
    end
endmodule

// File: rtl/dec_key_transform.sv
// Turns an encryption round key into the decryption round key K'r.
// Macro DECRYPT_KEY_THETA_EN:
//   defined   - rk_o = last_i ? key_i : theta(key_i)
//   undefined - key_i already is K'r; rk_o = key_i, no theta is built.
//  key_i   in  128  encryption round key from the key schedule
//  last_i  in  1    final round (K'12 = K0 passes through untouched)
//  rk_o    out 128  decryption round key
module dec_key_transform
    import anubis_pkg::*;
(
    input  logic [DATA_W-1:0] key_i,
    input  logic              last_i,
    output logic [DATA_W-1:0] rk_o
);
`ifdef DECRYPT_KEY_THETA_EN
    logic [DATA_W-1:0] key_theta;

    anubis_theta u_key_theta (.a_i(key_i), .b_o(key_theta));

    assign rk_o = last_i ? key_i : key_theta;
`else
    logic unused_last;

    assign unused_last = last_i;
    assign rk_o        = key_i;
`endif
endmodule

// File: rtl/decrypt_round.sv
// Anubis-128 decryption engine: 12 inverse rounds, one step per clock.
// Round keys K0..K12 are fetched from the key schedule in order 12..0.
// Optional macro DECRYPT_KEY_THETA_EN: apply theta to fetched keys
// internally (see dec_key_transform).
// Ports:
//  clk, reset          clock, synchronous active-high reset
//  start, cipher_text  accepted in IDLE (ready=1)
//  ready               idle, can accept start
//  key_req, key_idx    key request and encryption key index (12 - round)
//  key_valid, key_in   key response
//  plain_text, done    result (held) and one-cycle completion pulse
//
// Key handshake: key_req is held with a stable key_idx until a clock edge
// sees key_req & key_valid; that edge consumes key_in. key_valid while
// key_req is low has no effect, and key_valid may already be high in the
// first cycle of a request.
module decrypt_round
    import anubis_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] cipher_text,
    output logic              ready,
    output logic              key_req,
    output logic [3:0]        key_idx,
    input  logic              key_valid,
    input  logic [DATA_W-1:0] key_in,
    output logic [DATA_W-1:0] plain_text,
    output logic              done
);
    state_e            state_q, state_d;
    logic [3:0]        round_q, round_d;
    logic [DATA_W-1:0] st_q, st_d;
    logic [DATA_W-1:0] rk_q, rk_d;
    logic [DATA_W-1:0] pt_q, pt_d;

    logic [DATA_W-1:0] gamma_st, tau_st, theta_st, rk_next;
    logic              last_round;

    assign last_round = (round_q == 4'(ROUNDS));

    anubis_gamma u_gamma (.a_i(st_q), .b_o(gamma_st));
    anubis_tau   u_tau   (.a_i(st_q), .b_o(tau_st));
    anubis_theta u_theta (.a_i(st_q), .b_o(theta_st));

    dec_key_transform u_key_xf (
        .key_i  (key_in),
        .last_i (last_round),
        .rk_o   (rk_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            round_q <= '0;
            st_q    <= '0;
            rk_q    <= '0;
            pt_q    <= '0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            st_q    <= st_d;
            rk_q    <= rk_d;
            pt_q    <= pt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        st_d    = st_q;
        rk_d    = rk_q;
        pt_d    = pt_q;
        ready   = 1'b0;
        key_req = 1'b0;
        key_idx = 4'd0;
        done    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    st_d    = cipher_text;
                    round_d = 4'd0;
                    state_d = ST_KEY0;
                end
            end
            ST_KEY0: begin
                // K'0 = K12 is whitened in directly
                key_req = 1'b1;
                key_idx = 4'(ROUNDS);
                if (key_valid) begin
                    st_d    = st_q ^ key_in;
                    round_d = 4'd1;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                key_req = 1'b1;
                key_idx = 4'(ROUNDS) - round_q;
                if (key_valid) begin
                    rk_d    = rk_next;
                    state_d = ST_GAMMA;
                end
            end
            ST_GAMMA: begin
                st_d    = gamma_st;
                state_d = ST_TAU;
            end
            ST_TAU: begin
                st_d    = tau_st;
                state_d = last_round ? ST_SIGMA : ST_THETA;
            end
            ST_THETA: begin
                st_d    = theta_st;
                state_d = ST_SIGMA;
            end
            ST_SIGMA: begin
                st_d = st_q ^ rk_q;
                if (last_round) begin
                    pt_d    = st_q ^ rk_q;
                    state_d = ST_DONE;
                end else begin
                    round_d = round_q + 4'd1;
                    state_d = ST_FETCH;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign plain_text = pt_q;

endmodule

// File: tb/tb_decrypt_round.sv
// Directed bench for decrypt_round: encrypts with a reference model of the
// Anubis round, feeds the cipher text to the DUT and checks the recovered
// plain text, latency, key index order, reset and start-hold behaviour.
module tb_decrypt_round;

    logic         clk;
    logic         reset;
    logic         start;
    logic [127:0] cipher_text;
    logic         ready;
    logic         key_req;
    logic [3:0]   key_idx;
    logic         key_valid;
    logic [127:0] key_in;
    logic [127:0] plain_text;
    logic         done;

    int vectors     = 0;
    int miscompares = 0;

    logic [127:0] rk [13];
    logic [127:0] exp_q [$];

    int kdelay;
    int wait_cnt;
    int exp_idx;

    localparam logic [3:0] TB_P [16] = '{4'h3, 4'hF, 4'hE, 4'h0, 4'h5, 4'h4, 4'hB, 4'hC,
                                         4'hD, 4'hA, 4'h9, 4'h6, 4'h7, 4'h8, 4'h2, 4'h1};
    localparam logic [3:0] TB_Q [16] = '{4'h9, 4'hE, 4'h5, 4'h6, 4'hA, 4'h2, 4'h3, 4'hC,
                                         4'hF, 4'h0, 4'h4, 4'hD, 4'h7, 4'hB, 4'h1, 4'h8};
    localparam logic [7:0] TB_H [4] = '{8'h01, 8'h02, 8'h04, 8'h06};

    decrypt_round dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .cipher_text (cipher_text),
        .ready       (ready),
        .key_req     (key_req),
        .key_idx     (key_idx),
        .key_valid   (key_valid),
        .key_in      (key_in),
        .plain_text  (plain_text),
        .done        (done)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] x;
        r = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
        end
        return r;
    endfunction

    function automatic logic [7:0] tb_sbox(input logic [7:0] x);
        logic [3:0] u, l, u2, l2;
        u  = TB_P[x[7:4]];
        l  = TB_Q[x[3:0]];
        u2 = {u[3:2], l[3:2]};
        l2 = {u[1:0], l[1:0]};
        u  = TB_Q[u2];
        l  = TB_P[l2];
        u2 = {u[3:2], l[3:2]};
        l2 = {u[1:0], l[1:0]};
        return {TB_P[u2], TB_Q[l2]};
    endfunction

    function automatic logic [127:0] tb_gamma(input logic [127:0] a);
        logic [127:0] b;
        for (int k = 0; k < 16; k++) b[127 - 8*k -: 8] = tb_sbox(a[127 - 8*k -: 8]);
        return b;
    endfunction

    function automatic logic [127:0] tb_tau(input logic [127:0] a);
        logic [127:0] b;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                b[127 - 8*(4*i + j) -: 8] = a[127 - 8*(4*j + i) -: 8];
        return b;
    endfunction

    function automatic logic [127:0] tb_theta(input logic [127:0] a);
        logic [127:0] b;
        logic [7:0]   acc;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++)
                    acc = acc ^ tb_mul(a[127 - 8*(4*i + k) -: 8], TB_H[k ^ j]);
                b[127 - 8*(4*i + j) -: 8] = acc;
            end
        end
        return b;
    endfunction

    function automatic logic [127:0] tb_encrypt(input logic [127:0] pt);
        logic [127:0] s;
        s = pt ^ rk[0];
        for (int r = 1; r < 12; r++) s = tb_theta(tb_tau(tb_gamma(s))) ^ rk[r];
        s = tb_tau(tb_gamma(s)) ^ rk[12];
        return s;
    endfunction

    // Key as the key schedule presents it for encryption index idx.
    function automatic logic [127:0] supply_key(input int idx);
`ifdef DECRYPT_KEY_THETA_EN
        return rk[idx];
`else
        if (idx == 12 || idx == 0) return rk[idx];
        return tb_theta(rk[idx]);
`endif
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- driver / checker tasks ----------------
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Answers the key request visible in the current cycle.
    task automatic key_step();
        if (key_req) begin
            check("key_idx", 128'(key_idx), 128'(exp_idx));
            if (wait_cnt >= kdelay && exp_idx >= 0) begin
                key_valid = 1'b1;
                key_in    = supply_key(exp_idx);
                exp_idx   = exp_idx - 1;
                wait_cnt  = 0;
            end else begin
                key_valid = 1'b0;
                key_in    = rand128();
                wait_cnt  = wait_cnt + 1;
            end
        end else begin
            key_valid = (kdelay == 0);
            key_in    = rand128();
        end
    endtask

    task automatic load_keys(input bit zero);
        for (int i = 0; i < 13; i++) rk[i] = zero ? 128'd0 : rand128();
    endtask

    task automatic do_decrypt(input logic [127:0] pt, input int delay, input bit hold);
        logic [127:0] exp;
        int           n;
        bit           seen;
        exp_q.push_back(pt);
        kdelay   = delay;
        wait_cnt = 0;
        exp_idx  = 12;
        check("ready_before_start", 128'(ready), 128'(1));
        start       = 1'b1;
        cipher_text = tb_encrypt(pt);
        tick();
        if (!hold) begin
            start       = 1'b0;
            cipher_text = rand128();
        end
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 400) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                key_step();
                tick();
                n++;
            end
        end
        check("done_latency", 128'(n), 128'(60 + 13 * delay));
        check("keys_consumed", 128'(exp_idx), 128'(-1));
        exp = exp_q.pop_front();
        check("plain_text", plain_text, exp);
        tick();
        if (hold) start = 1'b0;
        check("done_pulse_width", 128'(done), 128'(0));
        check("ready_after_done", 128'(ready), 128'(1));
        check("plain_text_held", plain_text, exp);
        repeat (3) tick();
        check("single_run_ready", 128'(ready), 128'(1));
        check("single_run_done", 128'(done), 128'(0));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [127:0] pt;
        reset       = 1'b1;
        start       = 1'b0;
        cipher_text = '0;
        key_valid   = 1'b0;
        key_in      = '0;
        kdelay      = 0;
        wait_cnt    = 0;
        exp_idx     = 12;
        @(negedge clk);
        tick();
        tick();
        reset = 1'b0;

        // reset state
        check("rst_ready", 128'(ready), 128'(1));
        check("rst_key_req", 128'(key_req), 128'(0));
        check("rst_key_idx", 128'(key_idx), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        check("rst_plain_text", plain_text, 128'd0);

        // all-zero keys, plain text 0
        load_keys(1'b1);
        do_decrypt(128'd0, 0, 1'b0);

        // random keys and plain texts, key_valid tied high
        for (int s = 0; s < 12; s++) begin
            load_keys(1'b0);
            do_decrypt(rand128(), 0, 1'b0);
        end

        // directed patterns under one key set
        load_keys(1'b0);
        do_decrypt({128{1'b1}}, 0, 1'b0);
        do_decrypt(128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF, 0, 1'b0);

        // key stalls of 3 cycles on every request
        do_decrypt(rand128(), 3, 1'b0);
        load_keys(1'b0);
        do_decrypt(rand128(), 3, 1'b0);

        // reset in round 5 THETA
        load_keys(1'b0);
        pt       = rand128();
        kdelay   = 0;
        wait_cnt = 0;
        exp_idx  = 12;
        start       = 1'b1;
        cipher_text = tb_encrypt(pt);
        tick();
        start = 1'b0;
        for (int c = 0; c < 24; c++) begin
            key_step();
            tick();
        end
        check("busy_before_reset", 128'(ready), 128'(0));
        check("no_key_req_in_theta", 128'(key_req), 128'(0));
        reset = 1'b1;
        key_step();
        tick();
        reset = 1'b0;
        check("midrst_ready", 128'(ready), 128'(1));
        check("midrst_key_req", 128'(key_req), 128'(0));
        check("midrst_key_idx", 128'(key_idx), 128'(0));
        check("midrst_done", 128'(done), 128'(0));
        check("midrst_plain_text", plain_text, 128'd0);
        do_decrypt(pt, 0, 1'b0);

        // start held for the whole run and during DONE
        load_keys(1'b0);
        do_decrypt(rand128(), 0, 1'b1);
        do_decrypt(rand128(), 1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
